// File: rtl/nes_joypad_port_if.sv
// NES joypad serial bus: strobe and per-port read clocks from the console,
// one serial data bit per port back from the joypad port.
interface nes_joypad_port_if;
  logic       joypad_strobe;
  logic [1:0] joypad_clock;
  logic [1:0] joypad_data;

  // Console side drives strobe/clock and samples data.
  modport master (
    output joypad_strobe,
    output joypad_clock,
    input  joypad_data
  );

  // Joypad port side samples strobe/clock and drives data.
  modport slave (
    input  joypad_strobe,
    input  joypad_clock,
    output joypad_data
  );
endinterface

// File: rtl/nes_joypad_port.sv
// nes_joypad_port: turns raw DualShock button bytes for two players into the
// NES $4016/$4017 serial joypad protocol. Raw bytes arrive from the slow
// controller clock domain, so each bit is double-flopped, then the 16-bit
// word is debounced, mapped to the NES button set with opposite-direction
// suppression, and served through 8-bit read shift registers that fill
// with ones once all eight buttons have been read.
//
// Optional build macro JOYPAD_TURBO_EN: adds a free-running turbo phase;
// Triangle then acts as turbo A and Square as turbo B. Without the macro
// no turbo logic exists and Triangle/Square are ignored.
module nes_joypad_port #(
  parameter int STABLE_CYCLES = 1024,
  parameter int TURBO_DIV     = 630000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       joy_p1_b0,
  input  logic [7:0]       joy_p1_b1,
  input  logic [7:0]       joy_p2_b0,
  input  logic [7:0]       joy_p2_b1,
  nes_joypad_port_if.slave joy_bus,
  output logic [7:0]       btn_p1,
  output logic [7:0]       btn_p2
);

  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  // Reject parameter values that would make the debounce or turbo divider meaningless.
  if (STABLE_CYCLES < 2 || TURBO_DIV < 1) begin : g_param_check
    $error("nes_joypad_port: STABLE_CYCLES must be >= 2 and TURBO_DIV >= 1");
  end

  // Map an active-low DualShock word to active-high NES {R,L,D,U,St,Se,B,A},
  // clearing both members of any opposite-direction pair held together.
  function automatic logic [7:0] map_buttons(input logic [7:0] b0, input logic [7:0] b1);
    logic r, l, d, u;
    r = ~b0[5];
    l = ~b0[7];
    d = ~b0[6];
    u = ~b0[4];
    if (r && l) begin
      r = 1'b0;
      l = 1'b0;
    end else begin
      r = r;
      l = l;
    end
    if (u && d) begin
      u = 1'b0;
      d = 1'b0;
    end else begin
      u = u;
      d = d;
    end
    return {r, l, d, u, ~b0[3], ~b0[0], ~b1[6], ~b1[5]};
  endfunction

  logic [1:0][15:0]      raw_s;
  logic [1:0][15:0]      sync1_q, sync2_q, prev_q;
  logic [1:0][15:0]      prev_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]            commit_s;
  logic [1:0][7:0]       base_q, base_d;
  logic [1:0][7:0]       btn_q, btn_d;
  logic [1:0]            last_clk_q, last_clk_d;
  logic [1:0][7:0]       shreg_q, shreg_d;
  logic [1:0][3:0]       rdcnt_q, rdcnt_d;

  assign raw_s[0] = {joy_p1_b1, joy_p1_b0};
  assign raw_s[1] = {joy_p2_b1, joy_p2_b0};

  // Two-flop synchronisers for the raw bytes; reset to all-ones (released).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= {2{16'hFFFF}};
      sync2_q <= {2{16'hFFFF}};
    end else begin
      sync1_q <= raw_s;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: restart on any word change, saturate, commit the mapped word on reaching the limit.
  always_comb begin
    prev_d   = sync2_q;
    cnt_d    = cnt_q;
    commit_s = 2'b00;
    base_d   = base_q;
    for (int p = 0; p < 2; p++) begin
      if (sync2_q[p] != prev_q[p]) begin
        cnt_d[p] = {CNT_W{1'b0}};
      end else if (cnt_q[p] == CNT_MAX) begin
        cnt_d[p] = CNT_MAX;
      end else begin
        cnt_d[p] = cnt_q[p] + CNT_W'(1);
      end
      commit_s[p] = (cnt_d[p] == CNT_MAX);
      if (commit_s[p]) begin
        base_d[p] = map_buttons(sync2_q[p][7:0], sync2_q[p][15:8]);
      end else begin
        base_d[p] = base_q[p];
      end
    end
  end

  // Debounce state and committed button words.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= {2{16'hFFFF}};
      cnt_q  <= '0;
      base_q <= '0;
      btn_q  <= '0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
      base_q <= base_d;
      btn_q  <= btn_d;
    end
  end

`ifdef JOYPAD_TURBO_EN
  localparam int TDIV_W = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;
  localparam logic [TDIV_W-1:0] TDIV_MAX = TDIV_W'(TURBO_DIV - 1);

  logic [TDIV_W-1:0] turbo_cnt_q, turbo_cnt_d;
  logic              turbo_phase_q, turbo_phase_d;
  logic [1:0][1:0]   treq_q, treq_d;

  // Free-running turbo divider plus the committed Square/Triangle requests per player.
  always_comb begin
    if (turbo_cnt_q == TDIV_MAX) begin
      turbo_cnt_d   = {TDIV_W{1'b0}};
      turbo_phase_d = ~turbo_phase_q;
    end else begin
      turbo_cnt_d   = turbo_cnt_q + TDIV_W'(1);
      turbo_phase_d = turbo_phase_q;
    end
    treq_d = treq_q;
    btn_d  = base_d;
    for (int p = 0; p < 2; p++) begin
      if (commit_s[p]) begin
        treq_d[p] = {~sync2_q[p][15], ~sync2_q[p][12]};
      end else begin
        treq_d[p] = treq_q[p];
      end
      btn_d[p] = base_d[p] | {6'b000000, treq_d[p][1] & turbo_phase_d,
                                         treq_d[p][0] & turbo_phase_d};
    end
  end

  // Turbo divider, phase and request registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      turbo_cnt_q   <= {TDIV_W{1'b0}};
      turbo_phase_q <= 1'b0;
      treq_q        <= '0;
    end else begin
      turbo_cnt_q   <= turbo_cnt_d;
      turbo_phase_q <= turbo_phase_d;
      treq_q        <= treq_d;
    end
  end
`else
  // Without turbo the published buttons are exactly the committed mapping.
  always_comb begin
    btn_d = base_d;
  end
`endif

  // Read side: strobe reloads continuously; a falling read clock shifts in a one.
  always_comb begin
    last_clk_d = joy_bus.joypad_clock;
    shreg_d    = shreg_q;
    rdcnt_d    = rdcnt_q;
    for (int i = 0; i < 2; i++) begin
      if (joy_bus.joypad_strobe) begin
        shreg_d[i] = btn_q[i];
        rdcnt_d[i] = 4'd0;
      end else if (last_clk_q[i] && !joy_bus.joypad_clock[i]) begin
        shreg_d[i] = {1'b1, shreg_q[i][7:1]};
        if (rdcnt_q[i] == 4'd8) begin
          rdcnt_d[i] = 4'd8;
        end else begin
          rdcnt_d[i] = rdcnt_q[i] + 4'd1;
        end
      end else begin
        shreg_d[i] = shreg_q[i];
        rdcnt_d[i] = rdcnt_q[i];
      end
    end
  end

  // Read clock history, shift registers and read counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_clk_q <= 2'b00;
      shreg_q    <= '0;
      rdcnt_q    <= '0;
    end else begin
      last_clk_q <= last_clk_d;
      shreg_q    <= shreg_d;
      rdcnt_q    <= rdcnt_d;
    end
  end

  assign joy_bus.joypad_data = {shreg_q[1][0], shreg_q[0][0]};
  assign btn_p1              = btn_q[0];
  assign btn_p2              = btn_q[1];

endmodule

// File: tb/tb_nes_joypad_port.sv
// Self-checking bench for nes_joypad_port (STABLE_CYCLES=4, TURBO_DIV=8).
// Inputs change and outputs are sampled on the falling clk edge.
module tb_nes_joypad_port;
  localparam int STABLE = 4;
  localparam int TDIV   = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] joy_p1_b0 = 8'hFF, joy_p1_b1 = 8'hFF;
  logic [7:0] joy_p2_b0 = 8'hFF, joy_p2_b1 = 8'hFF;
  logic [7:0] btn_p1, btn_p2;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] exp_btn_q[$];
  logic       exp_bit_q[$];

  nes_joypad_port_if bus ();

  nes_joypad_port #(.STABLE_CYCLES(STABLE), .TURBO_DIV(TDIV)) dut (
    .clk      (clk),
    .reset    (reset),
    .joy_p1_b0(joy_p1_b0),
    .joy_p1_b1(joy_p1_b1),
    .joy_p2_b0(joy_p2_b0),
    .joy_p2_b1(joy_p2_b1),
    .joy_bus  (bus),
    .btn_p1   (btn_p1),
    .btn_p2   (btn_p2)
  );

  always #5 clk = ~clk;

  // Reference mapping: active-low pad word to active-high NES buttons.
  function automatic logic [7:0] model_btn(input logic [7:0] b0, input logic [7:0] b1);
    logic r, l, d, u;
    r = ~b0[5]; l = ~b0[7]; d = ~b0[6]; u = ~b0[4];
    if (r && l) begin r = 1'b0; l = 1'b0; end
    if (u && d) begin u = 1'b0; d = 1'b0; end
    return {r, l, d, u, ~b0[3], ~b0[0], ~b1[6], ~b1[5]};
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    joy_p1_b0 = 8'hFF; joy_p1_b1 = 8'hFF;
    joy_p2_b0 = 8'hFF; joy_p2_b1 = 8'hFF;
    bus.joypad_strobe = 1'b0;
    bus.joypad_clock  = 2'b00;
    cycles(2);
    reset = 1'b0;
  endtask

  task automatic strobe_load();
    bus.joypad_strobe = 1'b1;
    cycles(2);
    bus.joypad_strobe = 1'b0;
  endtask

  task automatic pulse(input logic [1:0] mask);
    bus.joypad_clock = mask;
    cycles(1);
    bus.joypad_clock = 2'b00;
    cycles(1);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    cycles(1);
    tests_run++;
    if (bus.joypad_data !== 2'b00) begin
      tests_failed++; $display("FAIL reset_data: got %b expected 00", bus.joypad_data);
    end
    tests_run++;
    if (btn_p1 !== 8'h00 || btn_p2 !== 8'h00) begin
      tests_failed++; $display("FAIL reset_btn: got %h/%h expected 00/00", btn_p1, btn_p2);
    end
    reset = 1'b0;
  endtask

  task automatic test_debounce();
    logic [7:0] got;
    apply_reset();
    cycles(6);
    joy_p1_b0 = 8'hF7;
    exp_btn_q.push_back(model_btn(8'hF7, 8'hFF));
    cycles(5);
    tests_run++;
    if (btn_p1 !== 8'h00) begin
      tests_failed++; $display("FAIL debounce_early: got %h expected 00 after 5 cycles", btn_p1);
    end
    cycles(1);
    got = btn_p1;
    tests_run++;
    if (got !== exp_btn_q[0]) begin
      tests_failed++; $display("FAIL debounce_commit: got %h expected %h after 6 cycles", got, exp_btn_q[0]);
    end
    void'(exp_btn_q.pop_front());
  endtask

  task automatic test_bounce();
    apply_reset();
    cycles(6);
    for (int k = 0; k < 8; k++) begin
      joy_p1_b0 = (k % 2 == 0) ? 8'hF7 : 8'hFF;
      cycles(2);
      tests_run++;
      if (btn_p1 !== 8'h00) begin
        tests_failed++; $display("FAIL bounce_%0d: got %h expected 00", k, btn_p1);
      end
    end
    joy_p1_b0 = 8'hFF;
    cycles(8);
  endtask

  task automatic test_full_read();
    logic [7:0] m;
    joy_p1_b0 = 8'hDF; joy_p1_b1 = 8'hDF;
    m = model_btn(8'hDF, 8'hDF);
    exp_btn_q.push_back(m);
    cycles(8);
    tests_run++;
    if (btn_p1 !== exp_btn_q[0]) begin
      tests_failed++; $display("FAIL read_btn: got %h expected %h", btn_p1, exp_btn_q[0]);
    end
    void'(exp_btn_q.pop_front());
    for (int i = 0; i < 8; i++) exp_bit_q.push_back(m[i]);
    for (int i = 0; i < 3; i++) exp_bit_q.push_back(1'b1);
    strobe_load();
    for (int n = 0; n <= 10; n++) begin
      if (n > 0) pulse(2'b01);
      tests_run++;
      if (bus.joypad_data[0] !== exp_bit_q[0]) begin
        tests_failed++; $display("FAIL read_bit_%0d: got %b expected %b", n, bus.joypad_data[0], exp_bit_q[0]);
      end
      void'(exp_bit_q.pop_front());
    end
  endtask

  task automatic test_suppression();
    joy_p2_b0 = 8'h5F;
    exp_btn_q.push_back(model_btn(8'h5F, 8'hFF));
    cycles(8);
    tests_run++;
    if (btn_p2 !== exp_btn_q[0]) begin
      tests_failed++; $display("FAIL suppress_lr: got %h expected %h", btn_p2, exp_btn_q[0]);
    end
    void'(exp_btn_q.pop_front());
    joy_p2_b0 = 8'h4F;
    exp_btn_q.push_back(model_btn(8'h4F, 8'hFF));
    cycles(8);
    tests_run++;
    if (btn_p2 !== exp_btn_q[0]) begin
      tests_failed++; $display("FAIL suppress_lru: got %h expected %h", btn_p2, exp_btn_q[0]);
    end
    void'(exp_btn_q.pop_front());
  endtask

  task automatic test_strobe_priority();
    logic [7:0] m;
    joy_p1_b0 = 8'hFF; joy_p1_b1 = 8'hBF;
    m = model_btn(8'hFF, 8'hBF);
    cycles(8);
    bus.joypad_strobe = 1'b1;
    bus.joypad_clock  = 2'b01;
    cycles(1);
    bus.joypad_clock  = 2'b00;
    cycles(1);
    tests_run++;
    if (bus.joypad_data[0] !== m[0]) begin
      tests_failed++; $display("FAIL strobe_priority: got %b expected %b", bus.joypad_data[0], m[0]);
    end
    bus.joypad_strobe = 1'b0;
    pulse(2'b01);
    tests_run++;
    if (bus.joypad_data[0] !== m[1]) begin
      tests_failed++; $display("FAIL strobe_then_shift: got %b expected %b", bus.joypad_data[0], m[1]);
    end
  endtask

  task automatic test_independence();
    logic [7:0] m1, m2;
    m1 = model_btn(8'hFF, 8'hBF);
    m2 = model_btn(8'h4F, 8'hFF);
    strobe_load();
    for (int i = 1; i <= 4; i++) exp_bit_q.push_back(m2[i]);
    for (int n = 1; n <= 4; n++) begin
      pulse(2'b10);
      tests_run++;
      if (bus.joypad_data[1] !== exp_bit_q[0]) begin
        tests_failed++; $display("FAIL port2_bit_%0d: got %b expected %b", n, bus.joypad_data[1], exp_bit_q[0]);
      end
      void'(exp_bit_q.pop_front());
      tests_run++;
      if (bus.joypad_data[0] !== m1[0]) begin
        tests_failed++; $display("FAIL port1_hold_%0d: got %b expected %b", n, bus.joypad_data[0], m1[0]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] m;
    joy_p1_b0 = 8'hF7; joy_p1_b1 = 8'hFF;
    m = model_btn(8'hF7, 8'hFF);
    cycles(8);
    strobe_load();
    pulse(2'b01); pulse(2'b01); pulse(2'b01);
    tests_run++;
    if (bus.joypad_data[0] !== m[3]) begin
      tests_failed++; $display("FAIL pre_reset_bit: got %b expected %b", bus.joypad_data[0], m[3]);
    end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (bus.joypad_data !== 2'b00) begin
      tests_failed++; $display("FAIL async_reset_data: got %b expected 00", bus.joypad_data);
    end
    tests_run++;
    if (btn_p1 !== 8'h00 || btn_p2 !== 8'h00) begin
      tests_failed++; $display("FAIL async_reset_btn: got %h/%h expected 00/00", btn_p1, btn_p2);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_turbo();
    apply_reset();
    joy_p1_b1 = 8'hEF;
    cycles(8);
`ifdef JOYPAD_TURBO_EN
    begin
      logic prev;
      int   n;
      prev = btn_p1[0];
      n = 0;
      while (btn_p1[0] === prev && n < 20) begin cycles(1); n++; end
      tests_run++;
      if (n >= 20) begin
        tests_failed++; $display("FAIL turbo_start: got no toggle in %0d cycles expected toggle", n);
      end
      for (int k = 0; k < 3; k++) begin
        prev = btn_p1[0];
        n = 0;
        while (btn_p1[0] === prev && n < 20) begin cycles(1); n++; end
        tests_run++;
        if (n != TDIV) begin
          tests_failed++; $display("FAIL turbo_period_%0d: got %0d cycles expected %0d", k, n, TDIV);
        end
      end
    end
`else
    for (int k = 0; k < 24; k++) begin
      tests_run++;
      if (btn_p1[0] !== 1'b0) begin
        tests_failed++; $display("FAIL no_turbo_%0d: got %b expected 0", k, btn_p1[0]);
      end
      cycles(1);
    end
`endif
  endtask

  initial begin
    bus.joypad_strobe = 1'b0;
    bus.joypad_clock  = 2'b00;
    test_reset();
    test_debounce();
    test_bounce();
    test_full_read();
    test_suppression();
    test_strobe_priority();
    test_independence();
    test_async_reset();
    test_turbo();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
